// File: rtl/r2sdf_butterfly_stage.sv
// Radix-2 SDF butterfly stage: one-cycle latency from an accepted sample, no backpressure.
// State, delay line and data outputs hold while in_valid is low.
module r2sdf_butterfly_stage #(
  parameter int DATA_WIDTH = 16,
  parameter int DELAY      = 32,
  parameter int TW_STRIDE  = 1,
  parameter int TW_WIDTH   = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_re,
  input  logic [DATA_WIDTH-1:0] in_im,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_re,
  output logic [DATA_WIDTH-1:0] out_im,
  output logic                  out_tw_en,
  output logic [TW_WIDTH-1:0]   out_tw_idx,
  output logic                  out_sof
);
  localparam int CW = $clog2(2 * DELAY);

  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  primed_q, primed_d;
  logic                  half;
  logic                  last_fill, first_sum;
  logic [DATA_WIDTH-1:0] dl_re_q [DELAY];
  logic [DATA_WIDTH-1:0] dl_im_q [DELAY];
  logic [DATA_WIDTH-1:0] fb_re, fb_im;
  logic [DATA_WIDTH:0]   sum_re, sum_im, dif_re, dif_im;
  logic [DATA_WIDTH-1:0] push_re, push_im, cand_re, cand_im;
  logic [TW_WIDTH-1:0]   tw_idx;
  logic                  unused_lsbs;

  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_re_q, out_im_q;
  logic                  out_tw_en_q;
  logic [TW_WIDTH-1:0]   out_tw_idx_q;
  logic                  out_sof_q;

  assign half      = cnt_q[CW-1];
  assign last_fill = (cnt_q == CW'(DELAY - 1));
  assign first_sum = (cnt_q == CW'(DELAY));
  assign fb_re     = dl_re_q[DELAY-1];
  assign fb_im     = dl_im_q[DELAY-1];

  // Operands widened by one sign bit so the sum/difference cannot wrap before the halving shift.
  assign sum_re = {fb_re[DATA_WIDTH-1], fb_re} + {in_re[DATA_WIDTH-1], in_re};
  assign sum_im = {fb_im[DATA_WIDTH-1], fb_im} + {in_im[DATA_WIDTH-1], in_im};
  assign dif_re = {fb_re[DATA_WIDTH-1], fb_re} - {in_re[DATA_WIDTH-1], in_re};
  assign dif_im = {fb_im[DATA_WIDTH-1], fb_im} - {in_im[DATA_WIDTH-1], in_im};
  assign unused_lsbs = ^{sum_re[0], sum_im[0], dif_re[0], dif_im[0]};

  assign push_re = half ? dif_re[DATA_WIDTH:1] : in_re;
  assign push_im = half ? dif_im[DATA_WIDTH:1] : in_im;
  assign cand_re = half ? sum_re[DATA_WIDTH:1] : fb_re;
  assign cand_im = half ? sum_im[DATA_WIDTH:1] : fb_im;
  assign tw_idx  = TW_WIDTH'((32'(cnt_q) & 32'(DELAY - 1)) * 32'(TW_STRIDE));

  assign cnt_d    = in_valid ? cnt_q + CW'(1) : cnt_q;
  assign primed_d = primed_q | (in_valid & last_fill);

  // Delay line is not reset; stale contents are masked by primed after reset.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      dl_re_q[0] <= push_re;
      dl_im_q[0] <= push_im;
      for (int i = 1; i < DELAY; i++) begin
        dl_re_q[i] <= dl_re_q[i-1];
        dl_im_q[i] <= dl_im_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q        <= '0;
      primed_q     <= 1'b0;
      out_valid_q  <= 1'b0;
      out_re_q     <= '0;
      out_im_q     <= '0;
      out_tw_en_q  <= 1'b0;
      out_tw_idx_q <= '0;
      out_sof_q    <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      primed_q    <= primed_d;
      out_valid_q <= in_valid & primed_q;
      out_sof_q   <= in_valid & primed_q & first_sum;
      if (in_valid) begin
        out_re_q     <= cand_re;
        out_im_q     <= cand_im;
        out_tw_en_q  <= ~half;
        out_tw_idx_q <= half ? '0 : tw_idx;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_re     = out_re_q;
  assign out_im     = out_im_q;
  assign out_tw_en  = out_tw_en_q;
  assign out_tw_idx = out_tw_idx_q;
  assign out_sof    = out_sof_q;

endmodule

// File: tb/tb_r2sdf_butterfly_stage.sv
// Scoreboard bench for r2sdf_butterfly_stage: three instances (DELAY 4, 16/stride 2, 32) share data,
// each with its own gated in_valid; a single monitor pops per-instance expectation queues.
module tb_r2sdf_butterfly_stage;
  typedef struct {
    logic [15:0] re;
    logic [15:0] im;
    logic        en;
    logic [5:0]  idx;
    logic        sof;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_re = '0, in_im = '0;
  logic [2:0]  sel = 3'b001;
  logic        v[3];

  logic        o_vld[3];
  logic [15:0] o_re[3], o_im[3];
  logic        o_en[3];
  logic [5:0]  o_idx[3];
  logic        o_sof[3];

  exp_t q[3][$];
  int   hre[$], him[$];
  int   total = 0, bad = 0, sof16_cnt = 0;

  always #5 clk = ~clk;

  assign v[0] = in_valid & sel[0];
  assign v[1] = in_valid & sel[1];
  assign v[2] = in_valid & sel[2];

  r2sdf_butterfly_stage #(.DATA_WIDTH(16), .DELAY(4), .TW_STRIDE(1), .TW_WIDTH(6)) u4 (
    .clk(clk), .rst(rst), .in_valid(v[0]), .in_re(in_re), .in_im(in_im),
    .out_valid(o_vld[0]), .out_re(o_re[0]), .out_im(o_im[0]),
    .out_tw_en(o_en[0]), .out_tw_idx(o_idx[0]), .out_sof(o_sof[0]));

  r2sdf_butterfly_stage #(.DATA_WIDTH(16), .DELAY(16), .TW_STRIDE(2), .TW_WIDTH(6)) u16 (
    .clk(clk), .rst(rst), .in_valid(v[1]), .in_re(in_re), .in_im(in_im),
    .out_valid(o_vld[1]), .out_re(o_re[1]), .out_im(o_im[1]),
    .out_tw_en(o_en[1]), .out_tw_idx(o_idx[1]), .out_sof(o_sof[1]));

  r2sdf_butterfly_stage #(.DATA_WIDTH(16), .DELAY(32), .TW_STRIDE(1), .TW_WIDTH(6)) u32 (
    .clk(clk), .rst(rst), .in_valid(v[2]), .in_re(in_re), .in_im(in_im),
    .out_valid(o_vld[2]), .out_re(o_re[2]), .out_im(o_im[2]),
    .out_tw_en(o_en[2]), .out_tw_idx(o_idx[2]), .out_sof(o_sof[2]));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  function automatic exp_t mk(input int re, input int im, input logic en, input int idx, input logic sof);
    exp_t e;
    e.re  = 16'(re);
    e.im  = 16'(im);
    e.en  = en;
    e.idx = 6'(idx);
    e.sof = sof;
    return e;
  endfunction

  function automatic int halve(input int a, input int b, input bit sub);
    int s;
    s = sub ? a - b : a + b;
    return s >>> 1;
  endfunction

  // Monitor: pop on every valid output, otherwise require the outputs to hold once streaming.
  logic [15:0] p_re[3], p_im[3];
  logic        p_en[3];
  logic [5:0]  p_idx[3];
  bit          seen[3];
  exp_t        me;
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        seen[k] = 1'b0;
      end else if (o_vld[k]) begin
        if (q[k].size() == 0) begin
          chk($sformatf("u%0d extra output", k), 64'(1), 64'(0));
        end else begin
          me = q[k].pop_front();
          chk($sformatf("u%0d out_re", k),     64'(o_re[k]),  64'(me.re));
          chk($sformatf("u%0d out_im", k),     64'(o_im[k]),  64'(me.im));
          chk($sformatf("u%0d out_tw_en", k),  64'(o_en[k]),  64'(me.en));
          chk($sformatf("u%0d out_tw_idx", k), 64'(o_idx[k]), 64'(me.idx));
          chk($sformatf("u%0d out_sof", k),    64'(o_sof[k]), 64'(me.sof));
        end
        if (k == 1 && o_sof[k]) sof16_cnt++;
        seen[k] = 1'b1;
      end else if (seen[k]) begin
        chk($sformatf("u%0d hold", k), 64'({o_re[k], o_im[k], o_en[k], o_idx[k], o_sof[k]}),
            64'({p_re[k], p_im[k], p_en[k], p_idx[k], 1'b0}));
      end
      p_re[k]  = o_re[k];
      p_im[k]  = o_im[k];
      p_en[k]  = o_en[k];
      p_idx[k] = o_idx[k];
    end
  end

  // Drives one accepted sample; DELAY 16/32 instances get expectations from a sample-history model.
  task automatic drive(input logic [15:0] re, input logic [15:0] im);
    int n, d, st, idx;
    exp_t e;
    bit has;
    @(negedge clk);
    in_valid = 1'b1;
    in_re    = re;
    in_im    = im;
    if (!sel[0]) begin
      d  = sel[1] ? 16 : 32;
      st = sel[1] ? 2 : 1;
      hre.push_back(int'($signed(re)));
      him.push_back(int'($signed(im)));
      n   = hre.size() - 1;
      idx = n % (2 * d);
      has = 1'b0;
      if (idx >= d) begin
        e = mk(halve(hre[n-d], hre[n], 1'b0), halve(him[n-d], him[n], 1'b0), 1'b0, 0, idx == d);
        has = 1'b1;
      end else if (n >= 2 * d) begin
        e = mk(halve(hre[n-2*d], hre[n-d], 1'b1), halve(him[n-2*d], him[n-d], 1'b1),
               1'b1, (idx * st) % 64, 1'b0);
        has = 1'b1;
      end
      if (has) q[sel[1] ? 1 : 2].push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  // Hand-computed results for x = 1024*{1..8} followed by zeros, DELAY=4.
  task automatic push_t1(input int cnt);
    exp_t t[8];
    for (int k = 0; k < 4; k++) begin
      t[k]   = mk(1024 * (k + 3), 0, 1'b0, 0, k == 0);
      t[k+4] = mk(-2048, 0, 1'b1, k, 1'b0);
    end
    for (int k = 0; k < cnt; k++) q[0].push_back(t[k]);
  endtask

  task automatic run_t1(input bit bubbles, input int nzero);
    for (int i = 1; i <= 8 + nzero; i++) begin
      if (bubbles && $urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      drive(i <= 8 ? 16'(1024 * i) : 16'h0000, 16'h0000);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    for (int k = 0; k < 3; k++) chk($sformatf("u%0d queue drained", k), 64'(q[k].size()), 64'(0));
    rst      = 1'b1;
    in_valid = 1'b0;
    #1;
    for (int k = 0; k < 3; k++)
      chk($sformatf("u%0d reset outputs", k),
          64'({o_vld[k], o_re[k], o_im[k], o_en[k], o_idx[k], o_sof[k]}), 64'(0));
    for (int k = 0; k < 3; k++) q[k].delete();
    hre.delete();
    him.delete();
    sof16_cnt = 0;
    @(negedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    sel = 3'b001;
    do_reset();

    // Basic block, then four flush zeros.
    push_t1(8);
    run_t1(1'b0, 4);
    idle(3);
    do_reset();

    // Saturation corners of the halving add/subtract.
    q[0].push_back(mk(16'h7FFF, 16'hFFFF, 1'b0, 0, 1'b1));
    q[0].push_back(mk(16'hFFFF, 16'h7FFF, 1'b0, 0, 1'b0));
    q[0].push_back(mk(0, 0, 1'b0, 0, 1'b0));
    q[0].push_back(mk(0, 0, 1'b0, 0, 1'b0));
    q[0].push_back(mk(16'h0000, 16'h8000, 1'b1, 0, 1'b0));
    q[0].push_back(mk(16'h8000, 16'h0000, 1'b1, 1, 1'b0));
    q[0].push_back(mk(0, 0, 1'b1, 2, 1'b0));
    q[0].push_back(mk(0, 0, 1'b1, 3, 1'b0));
    drive(16'h7FFF, 16'h8000);
    drive(16'h8000, 16'h7FFF);
    drive(16'h0000, 16'h0000);
    drive(16'h0000, 16'h0000);
    drive(16'h7FFF, 16'h7FFF);
    drive(16'h7FFF, 16'h7FFF);
    repeat (6) drive(16'h0000, 16'h0000);
    idle(3);
    do_reset();

    // Same block with random input bubbles.
    push_t1(8);
    run_t1(1'b1, 4);
    idle(3);
    do_reset();

    // Reset at cnt=2 of the first block, then at cnt=2 of the flush block mid-output.
    drive(16'd1024, 16'h0000);
    drive(16'd2048, 16'h0000);
    do_reset();
    push_t1(6);
    run_t1(1'b0, 2);
    do_reset();
    push_t1(8);
    run_t1(1'b0, 4);
    idle(3);
    do_reset();

    // DELAY=16, stride 2: ramp over two blocks plus flush.
    sel = 3'b010;
    for (int n = 0; n < 64; n++) drive(16'(n * 256), 16'(-n * 100));
    repeat (16) drive(16'h0000, 16'h0000);
    idle(3);
    chk("u16 sof count", 64'(sof16_cnt), 64'(2));
    do_reset();

    // DELAY=32: three back-to-back random blocks; valid must stay high once primed.
    sel = 3'b100;
    for (int n = 0; n < 224; n++) begin
      drive(n < 192 ? 16'($urandom) : 16'h0000, n < 192 ? 16'($urandom) : 16'h0000);
      if (n >= 33) chk("u32 continuous out_valid", 64'(o_vld[2]), 64'(1));
    end
    idle(3);
    do_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
